// File: rtl/spi_bitrev_pkg.sv
// Shared types and constants for the spi_bitrev_slave SPI test peripheral.
package spi_bitrev_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Modes 1 and 3 take data on the trailing SCK edge, modes 0 and 2 on the leading edge.
  function automatic logic sample_on_trail(input logic [1:0] mode);
    return (mode == MODE1) || (mode == MODE3);
  endfunction

endpackage

// File: rtl/spi_bitrev_slave_if.sv
// SPI pin bundle for spi_bitrev_slave; the debug signals exist only when
// SPI_BITREV_DEBUG_EN is defined.
interface spi_bitrev_slave_if #(
  parameter int WIDTH = 8
) ();

  logic sck;
  logic ss;
  logic mosi;
  logic miso;

`ifdef SPI_BITREV_DEBUG_EN
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [15:0]      frame_cnt;

  modport slave  (input sck, ss, mosi, output miso, rx_data, rx_valid, frame_cnt);
  modport master (output sck, ss, mosi, input miso, rx_data, rx_valid, frame_cnt);
`else
  modport slave  (input sck, ss, mosi, output miso);
  modport master (output sck, ss, mosi, input miso);
`endif

endinterface

// File: rtl/spi_pin_sync.sv
// Brings sck, ss and mosi into the clock domain and turns synchronised sck
// transitions into registered single-cycle leading/trailing edge strobes.
module spi_pin_sync
  import spi_bitrev_pkg::*;
#(
  parameter logic CPOL   = 1'b0,
  parameter int   STAGES = SYNC_STAGES
) (
  input  logic clock,
  input  logic resetn,
  input  logic sck,
  input  logic ss,
  input  logic mosi,
  output logic lead_edge,
  output logic trail_edge,
  output logic ss_s,
  output logic mosi_s
);

  logic [STAGES-1:0] sck_q;
  logic [STAGES-1:0] ss_q;
  logic [STAGES-1:0] mosi_q;
  logic              sck_d;
  logic              sck_s;

  assign sck_s  = sck_q[STAGES-1];
  assign ss_s   = ss_q[STAGES-1];
  assign mosi_s = mosi_q[STAGES-1];

  // Reset to the idle pin levels so releasing reset never fakes an edge or a select.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sck_q      <= {STAGES{CPOL}};
      ss_q       <= '1;
      mosi_q     <= '0;
      sck_d      <= CPOL;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
    end else begin
      sck_q      <= {sck_q[STAGES-2:0], sck};
      ss_q       <= {ss_q[STAGES-2:0], ss};
      mosi_q     <= {mosi_q[STAGES-2:0], mosi};
      sck_d      <= sck_s;
      lead_edge  <= (sck_d == CPOL) && (sck_s != CPOL);
      trail_edge <= (sck_d != CPOL) && (sck_s == CPOL);
    end
  end

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI slave that receives a WIDTH-bit word and returns it bit-reversed in the
// following WIDTH SCK cycles. Define SPI_BITREV_DEBUG_EN for rx_data/rx_valid/frame_cnt.
module spi_bitrev_slave
  import spi_bitrev_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter logic CPOL  = 1'b0,
  parameter logic CPHA  = 1'b0
) (
  input  logic                 clock,
  input  logic                 resetn,
  spi_bitrev_slave_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic lead_edge, trail_edge, ss_s, mosi_s;
  logic sample_edge, drive_edge;

  spi_pin_sync #(
    .CPOL   (CPOL),
    .STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clock      (clock),
    .resetn     (resetn),
    .sck        (bus.sck),
    .ss         (bus.ss),
    .mosi       (bus.mosi),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .ss_s       (ss_s),
    .mosi_s     (mosi_s)
  );

  assign sample_edge = sample_on_trail({CPOL, CPHA}) ? trail_edge : lead_edge;
  assign drive_edge  = sample_on_trail({CPOL, CPHA}) ? lead_edge  : trail_edge;

  state_t           state, state_nx;
  logic [WIDTH-1:0] rx_sh, rx_sh_nx;
  logic [WIDTH-1:0] tx_sh, tx_sh_nx;
  logic [WIDTH-1:0] rx_word;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [CNT_W-1:0] smp_cnt, smp_cnt_nx;
  logic             miso_r, miso_nx;

`ifdef SPI_BITREV_DEBUG_EN
  logic [WIDTH-1:0] rx_data_r, rx_data_nx;
  logic             rx_valid_r, rx_valid_nx;
  logic [15:0]      frame_cnt_r, frame_cnt_nx;
`endif

  assign rx_word = {rx_sh[WIDTH-2:0], mosi_s};

  // ss deassertion is tested first in every busy state, so it wins over any strobe.
  always_comb begin
    state_nx   = state;
    rx_sh_nx   = rx_sh;
    tx_sh_nx   = tx_sh;
    bit_cnt_nx = bit_cnt;
    smp_cnt_nx = smp_cnt;
    miso_nx    = miso_r;
`ifdef SPI_BITREV_DEBUG_EN
    rx_data_nx   = rx_data_r;
    rx_valid_nx  = 1'b0;
    frame_cnt_nx = frame_cnt_r;
`endif
    case (state)
      IDLE: begin
        if (!ss_s) begin
          state_nx   = RX;
          rx_sh_nx   = '0;
          bit_cnt_nx = '0;
          miso_nx    = 1'b1;
        end
      end
      RX: begin
        if (ss_s) begin
          state_nx   = IDLE;
          rx_sh_nx   = '0;
          bit_cnt_nx = '0;
          smp_cnt_nx = '0;
          miso_nx    = 1'b1;
        end else if (sample_edge) begin
          if (bit_cnt == LAST) begin
            state_nx   = TX;
            tx_sh_nx   = rx_word;
            bit_cnt_nx = '0;
            smp_cnt_nx = '0;
`ifdef SPI_BITREV_DEBUG_EN
            rx_data_nx  = rx_word;
            rx_valid_nx = 1'b1;
`endif
          end else begin
            rx_sh_nx   = rx_word;
            bit_cnt_nx = bit_cnt + ONE;
          end
        end else if (drive_edge) begin
          miso_nx = 1'b1;
        end
      end
      TX: begin
        if (ss_s) begin
          state_nx   = IDLE;
          rx_sh_nx   = '0;
          bit_cnt_nx = '0;
          smp_cnt_nx = '0;
          miso_nx    = 1'b1;
        end else begin
          if (drive_edge && (bit_cnt < FULL)) begin
            miso_nx    = tx_sh[bit_cnt[IDX_W-1:0]];
            bit_cnt_nx = bit_cnt + ONE;
          end
          if (sample_edge) begin
            if (smp_cnt == LAST) begin
              state_nx   = RX;
              bit_cnt_nx = '0;
              smp_cnt_nx = '0;
`ifdef SPI_BITREV_DEBUG_EN
              frame_cnt_nx = frame_cnt_r + 16'd1;
`endif
            end else begin
              smp_cnt_nx = smp_cnt + ONE;
            end
          end
        end
      end
      default: begin
        state_nx = IDLE;
        miso_nx  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      rx_sh   <= '0;
      tx_sh   <= '0;
      bit_cnt <= '0;
      smp_cnt <= '0;
      miso_r  <= 1'b1;
`ifdef SPI_BITREV_DEBUG_EN
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_cnt_r <= '0;
`endif
    end else begin
      state   <= state_nx;
      rx_sh   <= rx_sh_nx;
      tx_sh   <= tx_sh_nx;
      bit_cnt <= bit_cnt_nx;
      smp_cnt <= smp_cnt_nx;
      miso_r  <= miso_nx;
`ifdef SPI_BITREV_DEBUG_EN
      rx_data_r   <= rx_data_nx;
      rx_valid_r  <= rx_valid_nx;
      frame_cnt_r <= frame_cnt_nx;
`endif
    end
  end

  assign bus.miso = miso_r;

`ifdef SPI_BITREV_DEBUG_EN
  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Self-checking bench: four spi_bitrev_slave instances covering all SPI modes and
// widths 5/8/16, driven by a bit-banged master and checked against a word-level model.
module tb_spi_bitrev_slave;

  localparam int H = 8;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] sck_v;
  logic [3:0] ss_v;
  logic [3:0] mosi_v;
  logic [3:0] miso_v;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  spi_bitrev_slave_if #(.WIDTH(8))  bus0 ();
  spi_bitrev_slave_if #(.WIDTH(16)) bus1 ();
  spi_bitrev_slave_if #(.WIDTH(8))  bus2 ();
  spi_bitrev_slave_if #(.WIDTH(5))  bus3 ();

  assign bus0.sck = sck_v[0];  assign bus0.ss = ss_v[0];  assign bus0.mosi = mosi_v[0];
  assign bus1.sck = sck_v[1];  assign bus1.ss = ss_v[1];  assign bus1.mosi = mosi_v[1];
  assign bus2.sck = sck_v[2];  assign bus2.ss = ss_v[2];  assign bus2.mosi = mosi_v[2];
  assign bus3.sck = sck_v[3];  assign bus3.ss = ss_v[3];  assign bus3.mosi = mosi_v[3];
  assign miso_v[0] = bus0.miso;
  assign miso_v[1] = bus1.miso;
  assign miso_v[2] = bus2.miso;
  assign miso_v[3] = bus3.miso;

  spi_bitrev_slave #(.WIDTH(8),  .CPOL(1'b0), .CPHA(1'b0)) dut0 (.clock(clock), .resetn(resetn), .bus(bus0));
  spi_bitrev_slave #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) dut1 (.clock(clock), .resetn(resetn), .bus(bus1));
  spi_bitrev_slave #(.WIDTH(8),  .CPOL(1'b0), .CPHA(1'b1)) dut2 (.clock(clock), .resetn(resetn), .bus(bus2));
  spi_bitrev_slave #(.WIDTH(5),  .CPOL(1'b1), .CPHA(1'b0)) dut3 (.clock(clock), .resetn(resetn), .bus(bus3));

`ifdef SPI_BITREV_DEBUG_EN
  int valid_pulses0 = 0;
  always @(posedge clock) if (bus0.rx_valid) valid_pulses0 <= valid_pulses0 + 1;
`endif

  typedef struct {
    int          d;
    int          n;
    logic [31:0] word0;
    logic [31:0] word1;
    logic [31:0] resp0;
    logic [31:0] resp1;
  } vec_t;

  function automatic int dut_w(input int d);
    case (d)
      0: return 8;
      1: return 16;
      2: return 8;
      default: return 5;
    endcase
  endfunction

  function automatic logic dut_cpol(input int d);
    return (d == 1) || (d == 3);
  endfunction

  function automatic logic dut_cpha(input int d);
    return (d == 1) || (d == 2);
  endfunction

  function automatic logic [31:0] ones(input int w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

  // Word-level model: bit i of the received word comes back as bit w-1-i.
  function automatic logic [31:0] bitrev(input logic [31:0] word, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      if (((word >> i) & 32'd1) != 0) r = r | (32'd1 << (w - 1 - i));
    return r;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit-banged master: shifts nbits of word out MSB first and records miso at each sample point.
  task automatic spi_xfer(input int d, input int nbits, input logic [31:0] word, output logic [31:0] seen);
    int   w;
    logic cpol, cpha, b;
    w    = dut_w(d);
    cpol = dut_cpol(d);
    cpha = dut_cpha(d);
    seen = '0;
    for (int i = 0; i < nbits; i++) begin
      b = word[5'(w - 1 - i)];
      if (!cpha) begin
        mosi_v[d] = b;
        wait_clks(H);
        seen = {seen[30:0], miso_v[d]};
        sck_v[d] = ~cpol;
        wait_clks(H);
        sck_v[d] = cpol;
      end else begin
        sck_v[d]  = ~cpol;
        mosi_v[d] = b;
        wait_clks(H);
        seen = {seen[30:0], miso_v[d]};
        sck_v[d] = cpol;
        wait_clks(H);
      end
    end
  endtask

  task automatic ss_begin(input int d);
    ss_v[d] = 1'b0;
    wait_clks(H);
  endtask

  task automatic ss_end(input int d);
    wait_clks(H);
    ss_v[d] = 1'b1;
    wait_clks(4 * H);
  endtask

  // One receive phase (miso must idle high) followed by one return phase.
  task automatic apply_stimulus(input int d, input logic [31:0] word, input string tag, output logic [31:0] resp);
    logic [31:0] seen;
    spi_xfer(d, dut_w(d), word, seen);
    check_output({tag, " rx-phase miso"}, seen, ones(dut_w(d)));
    spi_xfer(d, dut_w(d), $urandom, resp);
  endtask

  initial begin
    vec_t        tbl [5];
    logic [31:0] seen, resp, word;
    int          n;

    tbl[0] = '{d: 0, n: 1, word0: 32'hB4,   word1: 32'h0,    resp0: 32'h2D,   resp1: 32'h0};
    tbl[1] = '{d: 1, n: 2, word0: 32'h8001, word1: 32'h1234, resp0: 32'h8001, resp1: 32'h2C48};
    tbl[2] = '{d: 2, n: 1, word0: 32'h01,   word1: 32'h0,    resp0: 32'h80,   resp1: 32'h0};
    tbl[3] = '{d: 3, n: 1, word0: 32'h13,   word1: 32'h0,    resp0: 32'h19,   resp1: 32'h0};
    tbl[4] = '{d: 2, n: 1, word0: 32'hC5,   word1: 32'h0,    resp0: 32'hA3,   resp1: 32'h0};

    sck_v  = 4'b1010;
    ss_v   = 4'hF;
    mosi_v = 4'h0;
    resetn = 1'b0;

    $display("[TB] reset with sck toggling and ss low");
    ss_v[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_clks(3);
      sck_v[0] = ~sck_v[0];
      mosi_v[0] = ~mosi_v[0];
    end
    check_output("reset miso", {28'h0, miso_v}, 32'hF);
    ss_v[0] = 1'b1;
    wait_clks(4);
    resetn = 1'b1;
    wait_clks(6);
    for (int i = 0; i < 4; i++) begin
      wait_clks(H);
      sck_v[0] = ~sck_v[0];
    end
    wait_clks(H);
    check_output("idle ss-high miso", {28'h0, miso_v}, 32'hF);

    $display("[TB] table-driven frames");
    for (int r = 0; r < 5; r++) begin
      ss_begin(tbl[r].d);
      apply_stimulus(tbl[r].d, tbl[r].word0, $sformatf("tbl%0d.0", r), resp);
      check_output($sformatf("tbl%0d.0 response", r), resp, tbl[r].resp0);
      if (tbl[r].n > 1) begin
        apply_stimulus(tbl[r].d, tbl[r].word1, $sformatf("tbl%0d.1", r), resp);
        check_output($sformatf("tbl%0d.1 response", r), resp, tbl[r].resp1);
      end
      ss_end(tbl[r].d);
`ifdef SPI_BITREV_DEBUG_EN
      if (r == 0) begin
        check_output("rx_valid pulses", valid_pulses0, 1);
        check_output("rx_data", {24'h0, bus0.rx_data}, 32'hB4);
      end
      if (r == 1) check_output("frame_cnt", {16'h0, bus1.frame_cnt}, 32'd2);
`endif
    end

    $display("[TB] mode 1 abort after 5 bits");
    ss_begin(2);
    spi_xfer(2, 5, 32'hFF, seen);
    ss_v[2] = 1'b1;
    wait_clks(3);
    check_output("abort miso", {31'h0, miso_v[2]}, 32'h1);
    wait_clks(4 * H);
    ss_begin(2);
    apply_stimulus(2, 32'h01, "post-abort", resp);
    check_output("post-abort response", resp, 32'h80);
    ss_end(2);

    $display("[TB] ss deassert during return phase");
    ss_begin(0);
    spi_xfer(0, 8, 32'h00, seen);
    spi_xfer(0, 2, 32'hFF, seen);
    wait_clks(6);
    check_output("mid-tx miso low", {31'h0, miso_v[0]}, 32'h0);
    ss_v[0] = 1'b1;
    wait_clks(2);
    check_output("ss-high +2 clk miso", {31'h0, miso_v[0]}, 32'h0);
    wait_clks(1);
    check_output("ss-high +3 clk miso", {31'h0, miso_v[0]}, 32'h1);
    wait_clks(4 * H);

    $display("[TB] reset pulse during return phase");
    ss_begin(0);
    spi_xfer(0, 8, 32'h00, seen);
    spi_xfer(0, 3, 32'hFF, seen);
    wait_clks(6);
    check_output("pre-reset miso low", {31'h0, miso_v[0]}, 32'h0);
    resetn = 1'b0;
    #1;
    check_output("async reset miso", {31'h0, miso_v[0]}, 32'h1);
    ss_v[0] = 1'b1;
    wait_clks(4);
    resetn = 1'b1;
    wait_clks(4 * H);
    ss_begin(0);
    apply_stimulus(0, 32'hF0, "post-reset", resp);
    check_output("post-reset response", resp, 32'h0F);
    ss_end(0);

    $display("[TB] ss rise coincident with last sample strobe");
`ifdef SPI_BITREV_DEBUG_EN
    n = valid_pulses0;
`endif
    ss_begin(0);
    spi_xfer(0, 7, 32'hFF, seen);
    mosi_v[0] = 1'b1;
    wait_clks(H);
    sck_v[0] = 1'b1;
    wait_clks(1);
    ss_v[0] = 1'b1;
    wait_clks(H);
    sck_v[0] = 1'b0;
    wait_clks(4 * H);
    check_output("coincident ss miso", {31'h0, miso_v[0]}, 32'h1);
`ifdef SPI_BITREV_DEBUG_EN
    check_output("coincident ss rx_valid", valid_pulses0, n);
`endif
    ss_begin(0);
    apply_stimulus(0, 32'h3A, "post-coincident", resp);
    check_output("post-coincident response", resp, 32'h5C);
    ss_end(0);

    $display("[TB] randomized sessions");
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < 4; s++) begin
        n = $urandom_range(1, 3);
        ss_begin(d);
        for (int k = 0; k < n; k++) begin
          word = $urandom & ones(dut_w(d));
          apply_stimulus(d, word, $sformatf("rand d%0d s%0d k%0d", d, s, k), resp);
          check_output($sformatf("rand d%0d s%0d k%0d word 0x%0h", d, s, k, word), resp, bitrev(word, dut_w(d)));
        end
        ss_end(d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
